// File: rtl/branch_seq_ctrl_if.sv
// Bundle between the branch control-step sequencer and its surroundings:
// instruction/memory status inputs, datapath enables, completion pulses and
// debug statistics.
interface branch_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  // Inputs to the sequencer
  logic             Run;
  logic [31:0]      IR;
  logic             CON;
  logic             Mem_ready;

  // Datapath control enables
  logic             PCout;
  logic             MARin;
  logic             IncPC;
  logic             Zin;
  logic             Zlowout;
  logic             PCin;
  logic             Read;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;
  logic             Gra;
  logic             Rout;
  logic             CONin;
  logic             Yin;
  logic             Cout;
  logic             ADD;

  // Status and statistics
  logic             Done;
  logic             NotBr;
  logic             Fault;
  logic             Busy;
  logic [CNT_W-1:0] Taken_cnt;
  logic [CNT_W-1:0] NTaken_cnt;

  modport slave (
    input  Run, IR, CON, Mem_ready,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
           Gra, Rout, CONin, Yin, Cout, ADD,
           Done, NotBr, Fault, Busy, Taken_cnt, NTaken_cnt
  );

  modport master (
    output Run, IR, CON, Mem_ready,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
           Gra, Rout, CONin, Yin, Cout, ADD,
           Done, NotBr, Fault, Busy, Taken_cnt, NTaken_cnt
  );
endinterface

// File: rtl/branch_seq_ctrl.sv
// Control-step sequencer for conditional branches (brzr/brnz/brpl/brmi).
// Fetch runs in T0-T2, branch execute in T3-T6. The branch target is only
// loaded into PC when the con_ff result (CON) is set during T6. Saturating
// taken/not-taken counters are kept for debug visibility.
module branch_seq_ctrl #(
  parameter logic [4:0] OPCODE_BR    = 5'b10010,
  parameter int         CNT_W        = 16,
  parameter int         MEM_WAIT_MAX = 8
) (
  input  logic               Clock,
  input  logic               Clear,
  branch_seq_ctrl_if.slave   bus
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  // Last T1 wait cycle that may still see Mem_ready before giving up
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  taken_q, taken_d;
  logic [CNT_W-1:0]  ntaken_q, ntaken_d;
  logic              is_br;
  logic              unused_ir;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign is_br     = (bus.IR[31:27] == OPCODE_BR);
  // Only the opcode field matters to this sequencer
  assign unused_ir = ^bus.IR[26:0];

  // State, wait counter and statistics registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      taken_q  <= '0;
      ntaken_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
    end
  end

  // Next-state, memory-wait timeout and branch outcome counting
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    taken_d  = taken_q;
    ntaken_d = ntaken_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Run) begin
          state_d = S_T0;
        end
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        // A late Mem_ready on the limit cycle still proceeds to T2
        if (bus.Mem_ready) begin
          state_d = S_T2;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_br) begin
          state_d = S_T4;
        end else begin
          state_d = bus.Run ? S_T0 : S_IDLE;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        if (bus.CON) begin
          taken_d = sat_inc(taken_q);
        end else begin
          ntaken_d = sat_inc(ntaken_q);
        end
        state_d = bus.Run ? S_T0 : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the datapath enables; PCin in T6 follows CON directly
  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CONin   = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.ADD     = 1'b0;
    bus.Done    = 1'b0;
    bus.NotBr   = 1'b0;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_br) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.CONin = 1'b1;
        end else begin
          bus.NotBr = 1'b1;
        end
      end
      S_T4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
      end
      S_T5: begin
        bus.Cout = 1'b1;
        bus.ADD  = 1'b1;
        bus.Zin  = 1'b1;
      end
      S_T6: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = bus.CON;
        bus.Done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Status flags and statistics taken straight from the registers
  always_comb begin
    bus.Fault      = (state_q == S_FAULT);
    bus.Busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    bus.Taken_cnt  = taken_q;
    bus.NTaken_cnt = ntaken_q;
  end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl. A 16-bit-counter instance and a
// 2-bit-counter instance see identical stimulus; the narrow one exposes
// counter saturation.
module tb_branch_seq_ctrl;

  localparam logic [4:0] OPC_BR  = 5'b10010;
  localparam logic [4:0] OPC_ALU = 5'b00011;

  logic Clock = 1'b0;
  logic Clear;
  int   vecs = 0;
  int   errs = 0;

  always #5 Clock = ~Clock;

  branch_seq_ctrl_if #(.CNT_W(16)) bus1 ();
  branch_seq_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus2.Run       = bus1.Run;
  assign bus2.IR        = bus1.IR;
  assign bus2.CON       = bus1.CON;
  assign bus2.Mem_ready = bus1.Mem_ready;

  branch_seq_ctrl #(.OPCODE_BR(5'b10010), .CNT_W(16), .MEM_WAIT_MAX(8)) u_dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus1)
  );

  branch_seq_ctrl #(.OPCODE_BR(5'b10010), .CNT_W(2), .MEM_WAIT_MAX(8)) u_dut_narrow (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus2)
  );

  // Bit order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Gra Rout CONin Yin Cout ADD
  logic [15:0] ctrl1;
  // Bit order: Done NotBr Fault Busy
  logic [3:0]  stat1;

  assign ctrl1 = {bus1.PCout, bus1.MARin, bus1.IncPC, bus1.Zin, bus1.Zlowout, bus1.PCin,
                  bus1.Read, bus1.MDRin, bus1.MDRout, bus1.IRin, bus1.Gra, bus1.Rout,
                  bus1.CONin, bus1.Yin, bus1.Cout, bus1.ADD};
  assign stat1 = {bus1.Done, bus1.NotBr, bus1.Fault, bus1.Busy};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Clear          = 1'b0;
    bus1.Run       = 1'b0;
    bus1.IR        = 32'h0;
    bus1.CON       = 1'b0;
    bus1.Mem_ready = 1'b0;
    tick();
    tick();
    vecs++;
    if (ctrl1 !== 16'h0000 || stat1 !== 4'b0000) begin
      errs++;
      $display("FAIL reset_hold: ctrl=%h stat=%b expected 0000/0000", ctrl1, stat1);
    end
    Clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (ctrl1 !== 16'h0000 || stat1 !== 4'b0000) begin
        errs++;
        $display("FAIL reset_idle[%0d]: ctrl=%h stat=%b expected 0000/0000", i, ctrl1, stat1);
      end
      vecs++;
      if (bus1.Taken_cnt !== 16'd0 || bus1.NTaken_cnt !== 16'd0) begin
        errs++;
        $display("FAIL reset_cnt[%0d]: taken=%0d ntaken=%0d expected 0/0",
                 i, bus1.Taken_cnt, bus1.NTaken_cnt);
      end
    end
  endtask

  task automatic test_branch(input logic con, input logic [15:0] exp_t6,
                             input int exp_taken, input int exp_ntaken);
    logic [15:0] exp_ctrl [7];
    exp_ctrl = '{16'hF000, 16'h0F00, 16'h00C0, 16'h0038, 16'h8004, 16'h1003, 16'h0000};
    exp_ctrl[6] = exp_t6;
    bus1.IR        = {OPC_BR, 27'h5A5A5A5};
    bus1.CON       = con;
    bus1.Mem_ready = 1'b1;
    bus1.Run       = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) bus1.Run = 1'b0;
      vecs++;
      if (ctrl1 !== exp_ctrl[i]) begin
        errs++;
        $display("FAIL branch_con%0b_ctrl[T%0d]: ctrl=%h expected %h", con, i, ctrl1, exp_ctrl[i]);
      end
      vecs++;
      if (stat1 !== ((i == 6) ? 4'b1001 : 4'b0001)) begin
        errs++;
        $display("FAIL branch_con%0b_stat[T%0d]: stat=%b expected %b", con, i, stat1,
                 (i == 6) ? 4'b1001 : 4'b0001);
      end
    end
    tick();
    vecs++;
    if (stat1 !== 4'b0000 || ctrl1 !== 16'h0000) begin
      errs++;
      $display("FAIL branch_con%0b_idle: ctrl=%h stat=%b expected 0000/0000", con, ctrl1, stat1);
    end
    vecs++;
    if (bus1.Taken_cnt !== 16'(exp_taken) || bus1.NTaken_cnt !== 16'(exp_ntaken)) begin
      errs++;
      $display("FAIL branch_con%0b_cnt: taken=%0d ntaken=%0d expected %0d/%0d", con,
               bus1.Taken_cnt, bus1.NTaken_cnt, exp_taken, exp_ntaken);
    end
  endtask

  task automatic test_not_branch(input int exp_taken, input int exp_ntaken);
    logic [15:0] exp_ctrl [9];
    logic [3:0]  exp_stat [9];
    exp_ctrl = '{16'hF000, 16'h0F00, 16'h00C0, 16'h0000,
                 16'hF000, 16'h0F00, 16'h00C0, 16'h0000, 16'h0000};
    exp_stat = '{4'b0001, 4'b0001, 4'b0001, 4'b0101,
                 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0000};
    bus1.IR        = {OPC_ALU, 27'h7FFFFFF};
    bus1.CON       = 1'b1;
    bus1.Mem_ready = 1'b1;
    bus1.Run       = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 4) bus1.Run = 1'b0;
      vecs++;
      if (ctrl1 !== exp_ctrl[i] || stat1 !== exp_stat[i]) begin
        errs++;
        $display("FAIL notbr[%0d]: ctrl=%h stat=%b expected %h/%b", i, ctrl1, stat1,
                 exp_ctrl[i], exp_stat[i]);
      end
    end
    vecs++;
    if (bus1.Taken_cnt !== 16'(exp_taken) || bus1.NTaken_cnt !== 16'(exp_ntaken)) begin
      errs++;
      $display("FAIL notbr_cnt: taken=%0d ntaken=%0d expected %0d/%0d",
               bus1.Taken_cnt, bus1.NTaken_cnt, exp_taken, exp_ntaken);
    end
  endtask

  task automatic test_back_to_back(input int exp_taken, input int exp_ntaken);
    logic [15:0] exp_ctrl [7];
    exp_ctrl = '{16'hF000, 16'h0F00, 16'h00C0, 16'h0038, 16'h8004, 16'h1003, 16'h0C00};
    bus1.IR        = {OPC_BR, 27'h0};
    bus1.CON       = 1'b1;
    bus1.Mem_ready = 1'b1;
    bus1.Run       = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 7) bus1.Run = 1'b0;
      vecs++;
      if (ctrl1 !== exp_ctrl[i % 7] || stat1 !== ((i % 7 == 6) ? 4'b1001 : 4'b0001)) begin
        errs++;
        $display("FAIL b2b[%0d]: ctrl=%h stat=%b expected %h", i, ctrl1, stat1, exp_ctrl[i % 7]);
      end
    end
    tick();
    vecs++;
    if (stat1 !== 4'b0000 || bus1.Taken_cnt !== 16'(exp_taken) ||
        bus1.NTaken_cnt !== 16'(exp_ntaken)) begin
      errs++;
      $display("FAIL b2b_end: stat=%b taken=%0d ntaken=%0d expected 0000 %0d/%0d", stat1,
               bus1.Taken_cnt, bus1.NTaken_cnt, exp_taken, exp_ntaken);
    end
  endtask

  task automatic test_mem_timeout();
    logic [15:0] exp_ctrl [5];
    exp_ctrl = '{16'h00C0, 16'h0038, 16'h8004, 16'h1003, 16'h0C00};
    bus1.IR        = {OPC_BR, 27'h0};
    bus1.CON       = 1'b1;
    bus1.Mem_ready = 1'b0;
    bus1.Run       = 1'b1;
    tick();
    bus1.Run = 1'b0;
    vecs++;
    if (ctrl1 !== 16'hF000) begin
      errs++;
      $display("FAIL tmo_t0: ctrl=%h expected f000", ctrl1);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vecs++;
      if (ctrl1 !== 16'h0F00 || stat1 !== 4'b0001) begin
        errs++;
        $display("FAIL tmo_wait[%0d]: ctrl=%h stat=%b expected 0f00/0001", k, ctrl1, stat1);
      end
    end
    tick();
    vecs++;
    if (ctrl1 !== 16'h0000 || stat1 !== 4'b0010) begin
      errs++;
      $display("FAIL tmo_fault: ctrl=%h stat=%b expected 0000/0010", ctrl1, stat1);
    end
    bus1.Run       = 1'b1;
    bus1.Mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (ctrl1 !== 16'h0000 || stat1 !== 4'b0010) begin
        errs++;
        $display("FAIL tmo_sticky[%0d]: ctrl=%h stat=%b expected 0000/0010", k, ctrl1, stat1);
      end
    end
    Clear    = 1'b0;
    bus1.Run = 1'b0;
    #1;
    vecs++;
    if (ctrl1 !== 16'h0000 || stat1 !== 4'b0000 || bus1.Taken_cnt !== 16'd0 ||
        bus1.NTaken_cnt !== 16'd0) begin
      errs++;
      $display("FAIL tmo_clear: ctrl=%h stat=%b taken=%0d ntaken=%0d expected all 0",
               ctrl1, stat1, bus1.Taken_cnt, bus1.NTaken_cnt);
    end
    #2;
    Clear = 1'b1;
    // Memory answers on the eighth and last allowed T1 cycle
    bus1.Mem_ready = 1'b0;
    bus1.Run       = 1'b1;
    tick();
    bus1.Run = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vecs++;
      if (ctrl1 !== 16'h0F00 || stat1 !== 4'b0001) begin
        errs++;
        $display("FAIL late_wait[%0d]: ctrl=%h stat=%b expected 0f00/0001", k, ctrl1, stat1);
      end
      if (k == 8) bus1.Mem_ready = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (ctrl1 !== exp_ctrl[i] || stat1[1] !== 1'b0) begin
        errs++;
        $display("FAIL late_exec[T%0d]: ctrl=%h stat=%b expected %h no fault", i + 2, ctrl1,
                 stat1, exp_ctrl[i]);
      end
    end
    tick();
    vecs++;
    if (stat1 !== 4'b0000 || bus1.Taken_cnt !== 16'd1 || bus1.NTaken_cnt !== 16'd0) begin
      errs++;
      $display("FAIL late_end: stat=%b taken=%0d ntaken=%0d expected 0000 1/0", stat1,
               bus1.Taken_cnt, bus1.NTaken_cnt);
    end
  endtask

  task automatic test_clear_mid();
    bus1.IR        = {OPC_BR, 27'h0};
    bus1.CON       = 1'b1;
    bus1.Mem_ready = 1'b1;
    bus1.Run       = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vecs++;
    if (ctrl1 !== 16'h1003) begin
      errs++;
      $display("FAIL clrmid_t5: ctrl=%h expected 1003", ctrl1);
    end
    Clear    = 1'b0;
    bus1.Run = 1'b0;
    #1;
    vecs++;
    if (ctrl1 !== 16'h0000 || stat1 !== 4'b0000 || bus1.Taken_cnt !== 16'd0 ||
        bus1.NTaken_cnt !== 16'd0) begin
      errs++;
      $display("FAIL clrmid_async: ctrl=%h stat=%b taken=%0d ntaken=%0d expected all 0",
               ctrl1, stat1, bus1.Taken_cnt, bus1.NTaken_cnt);
    end
    #2;
    Clear = 1'b1;
    tick();
    vecs++;
    if (ctrl1 !== 16'h0000 || stat1 !== 4'b0000) begin
      errs++;
      $display("FAIL clrmid_idle: ctrl=%h stat=%b expected 0000/0000", ctrl1, stat1);
    end
  endtask

  task automatic test_saturation();
    int done_cnt;
    done_cnt       = 0;
    bus1.IR        = {OPC_BR, 27'h1234567};
    bus1.CON       = 1'b1;
    bus1.Mem_ready = 1'b1;
    bus1.Run       = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 29) bus1.Run = 1'b0;
      if (bus1.Done === 1'b1) done_cnt++;
    end
    tick();
    vecs++;
    if (done_cnt != 5 || stat1 !== 4'b0000) begin
      errs++;
      $display("FAIL sat_done: done=%0d stat=%b expected 5/0000", done_cnt, stat1);
    end
    vecs++;
    if (bus1.Taken_cnt !== 16'd5) begin
      errs++;
      $display("FAIL sat_wide: taken=%0d expected 5", bus1.Taken_cnt);
    end
    vecs++;
    if (bus2.Taken_cnt !== 2'd3 || bus2.NTaken_cnt !== 2'd0) begin
      errs++;
      $display("FAIL sat_narrow: taken=%0d ntaken=%0d expected 3/0", bus2.Taken_cnt,
               bus2.NTaken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_branch(1'b1, 16'h0C00, 1, 0);
    test_branch(1'b0, 16'h0800, 1, 1);
    test_not_branch(1, 1);
    test_back_to_back(3, 1);
    test_mem_timeout();
    test_clear_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
